sram_port_arbiter: RTL and testbench

//  Shares one external-SRAM command port between two requesters: a write

---
 rtl/sram_port_arbiter_if.sv | 40 ++++
 rtl/sram_port_arbiter.sv | 114 +++++++++++
 tb/tb_sram_port_arbiter.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Handshake bundle between the two requesters, the arbiter and the SRAM adapter.
//   wr_*          write requester (valid/ready, address, data)
//   rd_*          read requester (valid/ready, address)
//   rd_rsp_*      read response pulse and data
//   mem_cmd_*     registered command stage toward the SRAM adapter
//   mem_rdata     SRAM read data, valid RD_LAT cycles after read command accept
// slave  : arbiter view
// master : environment view (requesters + adapter)
interface sram_port_arbiter_if #(
  parameter int AW = 18,
  parameter int DW = 32
);
  logic          wr_valid;
  logic          wr_ready;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic          rd_ready;
  logic [AW-1:0] rd_addr;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_rsp_data;
  logic          mem_cmd_valid;
  logic          mem_cmd_ready;
  logic          mem_cmd_we;
  logic [AW-1:0] mem_cmd_addr;
  logic [DW-1:0] mem_cmd_wdata;
  logic [DW-1:0] mem_rdata;

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_cmd_ready, mem_rdata,
    output wr_ready, rd_ready, rd_rsp_valid, rd_rsp_data,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata
  );

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, mem_cmd_ready, mem_rdata,
    input  wr_ready, rd_ready, rd_rsp_valid, rd_rsp_data,
           mem_cmd_valid, mem_cmd_we, mem_cmd_addr, mem_cmd_wdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM command port between a write requester (pcode initialiser)
// and a read requester (correlator). Round-robin grant into a single
// registered command stage; read data returns a fixed RD_LAT cycles after
// the adapter accepts the read command, plus one output register.
// Ports:
//   clk    system clock
//   rst_n  asynchronous reset, active-low
//   bus    sram_port_arbiter_if.slave (requesters, response, SRAM command)
//
// state (last_grant) | meaning
// GRANT_RD           | read won most recently; write wins a tie next
// GRANT_WR           | write won most recently; read wins a tie next
module sram_port_arbiter #(
  parameter int AW     = 18,
  parameter int DW     = 32,
  parameter int RD_LAT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sram_port_arbiter_if.slave   bus
);

  typedef enum logic {GRANT_RD = 1'b0, GRANT_WR = 1'b1} grant_e;

  grant_e            last_grant_q, last_grant_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              cmd_we_q, cmd_we_d;
  logic [AW-1:0]     cmd_addr_q, cmd_addr_d;
  logic [DW-1:0]     cmd_wdata_q, cmd_wdata_d;
  logic [RD_LAT-1:0] tag_pipe_q, tag_pipe_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_data_q, rsp_data_d;

  logic stage_free;
  logic grant_wr;
  logic wr_accept;
  logic rd_accept;
  logic tag_in;

  always_comb begin
    stage_free = !cmd_valid_q || bus.mem_cmd_ready;

    // A lone requester always wins; on a tie the one not served last wins.
    if (bus.wr_valid && bus.rd_valid) grant_wr = (last_grant_q == GRANT_RD);
    else                              grant_wr = bus.wr_valid;

    wr_accept = stage_free && bus.wr_valid && grant_wr;
    rd_accept = stage_free && bus.rd_valid && !grant_wr;

    last_grant_d = last_grant_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_we_d     = cmd_we_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;

    if (wr_accept) begin
      cmd_valid_d  = 1'b1;
      cmd_we_d     = 1'b1;
      cmd_addr_d   = bus.wr_addr;
      cmd_wdata_d  = bus.wr_data;
      last_grant_d = GRANT_WR;
    end else if (rd_accept) begin
      // wdata is left as-is for reads; the adapter ignores it.
      cmd_valid_d  = 1'b1;
      cmd_we_d     = 1'b0;
      cmd_addr_d   = bus.rd_addr;
      last_grant_d = GRANT_RD;
    end else if (stage_free) begin
      cmd_valid_d  = 1'b0;
    end

    // One tag per read command handed to the adapter; it exits exactly when
    // the adapter's mem_rdata for that command is valid.
    tag_in        = cmd_valid_q && bus.mem_cmd_ready && !cmd_we_q;
    tag_pipe_d    = '0;
    tag_pipe_d[0] = tag_in;
    for (int i = 1; i < RD_LAT; i++) tag_pipe_d[i] = tag_pipe_q[i-1];

    rsp_valid_d = tag_pipe_q[RD_LAT-1];
    rsp_data_d  = rsp_valid_d ? bus.mem_rdata : rsp_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= GRANT_RD;
      cmd_valid_q  <= 1'b0;
      cmd_we_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
      tag_pipe_q   <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_we_q     <= cmd_we_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
      tag_pipe_q   <= tag_pipe_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.wr_ready      = wr_accept;
  assign bus.rd_ready      = rd_accept;
  assign bus.mem_cmd_valid = cmd_valid_q;
  assign bus.mem_cmd_we    = cmd_we_q;
  assign bus.mem_cmd_addr  = cmd_addr_q;
  assign bus.mem_cmd_wdata = cmd_wdata_q;
  assign bus.rd_rsp_valid  = rsp_valid_q;
  assign bus.rd_rsp_data   = rsp_data_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
module tb_sram_port_arbiter;
  localparam int AW     = 18;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  int   rd_ready_hits = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  sram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // SRAM adapter model: writes land at the accepting edge, read data appears
  // RD_LAT cycles after the read command is accepted.
  logic [DW-1:0] mem [2048];
  logic [DW-1:0] rd_pipe [RD_LAT];

  always @(posedge clk) begin
    if (bus.mem_cmd_valid && bus.mem_cmd_ready && bus.mem_cmd_we)
      mem[bus.mem_cmd_addr[10:0]] <= bus.mem_cmd_wdata;
    rd_pipe[0] <= (bus.mem_cmd_valid && bus.mem_cmd_ready && !bus.mem_cmd_we)
                  ? mem[bus.mem_cmd_addr[10:0]] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign bus.mem_rdata = rd_pipe[RD_LAT-1];

  typedef struct {
    int            cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;
  typedef struct {
    int            cyc;
    logic [DW-1:0] data;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  always @(negedge clk) begin
    if (rst_n && bus.mem_cmd_valid && bus.mem_cmd_ready)
      cmd_q.push_back('{cyc, bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_wdata});
    if (bus.rd_rsp_valid)
      rsp_q.push_back('{cyc, bus.rd_rsp_data});
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // All driving tasks start and end #1 after a rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    bus.mem_cmd_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit done = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = a;
    bus.wr_data  = d;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.rd_ready) rd_ready_hits++;
      if (bus.wr_ready) done = 1'b1;
    end
    if (!done) check_eq("wr_timeout", 64'(done), 64'd1);
    @(posedge clk);
    #1 bus.wr_valid = 1'b0;
  endtask

  task automatic do_read(input logic [AW-1:0] a, output int acc);
    bit done = 1'b0;
    acc = -1;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = a;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.rd_ready) begin
        done = 1'b1;
        acc  = cyc;
      end
    end
    if (!done) check_eq("rd_timeout", 64'(done), 64'd1);
    @(posedge clk);
    #1 bus.rd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int n);
    for (int k = 0; k < 40 && rsp_q.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("rsp_count", 64'(rsp_q.size()), 64'(n));
  endtask

  initial begin
    int a0, a1, a2;
    int order_err, gap_err;
    logic [63:0] prod;

    rst_n = 1'b0;
    bus.wr_valid = 1'b0;
    bus.wr_addr  = '0;
    bus.wr_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rd_addr  = '0;
    bus.mem_cmd_ready = 1'b1;

    // Reset values
    @(posedge clk);
    #1;
    check_eq("rst_outputs",
             64'({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_wdata,
                  bus.rd_rsp_valid}), 64'd0);
    check_eq("rst_rsp_data", 64'(bus.rd_rsp_data), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: write-only stream, back-to-back
    cmd_q.delete();
    rd_ready_hits = 0;
    for (int i = 0; i <= 1000; i++) begin
      prod = 64'(i) * 64'd10000000;
      do_write(AW'(i), prod[31:0]);
    end
    repeat (3) @(posedge clk);
    #1;
    check_eq("t1_cmd_count", 64'(cmd_q.size()), 64'd1001);
    order_err = 0;
    gap_err   = 0;
    foreach (cmd_q[j]) begin
      prod = 64'(j) * 64'd10000000;
      if (!cmd_q[j].we || cmd_q[j].addr != AW'(j) || cmd_q[j].wdata != prod[31:0])
        order_err++;
      if (j > 0 && cmd_q[j].cyc != cmd_q[j-1].cyc + 1) gap_err++;
    end
    check_eq("t1_order", 64'(order_err), 64'd0);
    check_eq("t1_back_to_back", 64'(gap_err), 64'd0);
    check_eq("t1_rd_ready_low", 64'(rd_ready_hits), 64'd0);

    // 3: write then read same address, latency 1 + RD_LAT + 1
    apply_reset();
    rsp_q.delete();
    do_write(AW'(5), 32'hDEADBEEF);
    do_read(AW'(5), a0);
    wait_rsp(1);
    if (rsp_q.size() >= 1) begin
      check_eq("t3_latency", 64'(rsp_q[0].cyc - a0), 64'd4);
      check_eq("t3_data", 64'(rsp_q[0].data), 64'hDEADBEEF);
    end

    // 2: both valid continuously -> W,R,W,R,...
    apply_reset();
    bus.wr_valid = 1'b1;
    bus.rd_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.wr_addr = AW'(100 + k);
      bus.wr_data = 32'(k);
      bus.rd_addr = AW'(200 + k);
      @(negedge clk);
      check_eq($sformatf("t2_grant%0d", k), 64'({bus.wr_ready, bus.rd_ready}),
               (k % 2 == 0) ? 64'b10 : 64'b01);
      @(posedge clk);
      #1;
    end
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;

    // 4: adapter stall holds the command stage
    bus.mem_cmd_ready = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = AW'(18'h77);
    bus.wr_data  = 32'h1234;
    @(negedge clk);
    check_eq("t4_wr_accept", 64'(bus.wr_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.wr_valid = 1'b0;
    bus.rd_valid = 1'b1;
    bus.rd_addr  = AW'(18'h88);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check_eq($sformatf("t4_hold%0d", k),
               64'({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr, bus.mem_cmd_wdata,
                    bus.wr_ready, bus.rd_ready}),
               64'({1'b1, 1'b1, 18'h77, 32'h1234, 1'b0, 1'b0}));
      @(posedge clk);
      #1;
    end
    bus.mem_cmd_ready = 1'b1;
    @(negedge clk);
    check_eq("t4_release_grant", 64'(bus.rd_ready), 64'd1);
    @(posedge clk);
    #1 bus.rd_valid = 1'b0;
    @(negedge clk);
    check_eq("t4_next_cmd", 64'({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr}),
             64'({1'b1, 1'b0, 18'h88}));
    @(posedge clk);
    #1;
    repeat (8) @(posedge clk);
    #1;

    // 5: three consecutive reads -> three consecutive responses
    do_write(AW'(10), 32'h1111000A);
    do_write(AW'(11), 32'h2222000B);
    do_write(AW'(12), 32'h3333000C);
    rsp_q.delete();
    do_read(AW'(10), a0);
    do_read(AW'(11), a1);
    do_read(AW'(12), a2);
    check_eq("t5_accept_consec", 64'({a1 - a0, a2 - a1}), 64'({32'd1, 32'd1}));
    wait_rsp(3);
    if (rsp_q.size() >= 3) begin
      check_eq("t5_latency", 64'(rsp_q[0].cyc - a0), 64'd4);
      check_eq("t5_consec", 64'({rsp_q[1].cyc - rsp_q[0].cyc, rsp_q[2].cyc - rsp_q[1].cyc}),
               64'({32'd1, 32'd1}));
      check_eq("t5_data0", 64'(rsp_q[0].data), 64'h1111000A);
      check_eq("t5_data1", 64'(rsp_q[1].data), 64'h2222000B);
      check_eq("t5_data2", 64'(rsp_q[2].data), 64'h3333000C);
    end

    // 6: reset with two reads in flight drops them
    repeat (4) @(posedge clk);
    #1;
    do_read(AW'(10), a0);
    do_read(AW'(11), a1);
    @(posedge clk);
    #1 rst_n = 1'b0;
    rsp_q.delete();
    #1;
    check_eq("t6_rst_now",
             64'({bus.mem_cmd_valid, bus.mem_cmd_we, bus.mem_cmd_addr, bus.rd_rsp_valid}),
             64'd0);
    check_eq("t6_rst_data", 64'(bus.rd_rsp_data), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check_eq("t6_no_stale_rsp", 64'(rsp_q.size()), 64'd0);
    do_read(AW'(12), a2);
    wait_rsp(1);
    if (rsp_q.size() >= 1) begin
      check_eq("t6_new_latency", 64'(rsp_q[0].cyc - a2), 64'd4);
      check_eq("t6_new_data", 64'(rsp_q[0].data), 64'h3333000C);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
